// File: rtl/conv_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : conv_result_drain
// Purpose  : Output stage behind the 3x3 line-buffer convolution block.
//            Clamps each IN_W-bit result to OUT_W bits and stores it in a
//            DEPTH-entry first-word-fall-through FIFO. Pixels leave over a
//            valid/ready handshake. The block marks the last pixel of a
//            frame, pulses frame_done once the frame has fully drained, and
//            keeps sticky overflow and frame-length error flags.
// Ports    : clk        rising-edge clock
//            rst        asynchronous, active-low reset
//            in_en      result strobe, one cycle per pixel
//            in_data    unsigned convolution result [IN_W]
//            in_done    end-of-frame pulse from the convolution block
//            out_ready  downstream accepts a pixel this cycle
//            out_valid  out_data holds a pixel
//            out_data   saturated pixel [OUT_W]
//            out_last   high with the FRAME_PIX-th pixel of the frame
//            frame_done one-cycle pulse, frame fully drained
//            overflow   sticky, a result was dropped on a full FIFO
//            frame_err  sticky, drained pixel count != FRAME_PIX
// Revision : 1.0  initial release
// ============================================================================
module conv_result_drain #(
    parameter int IN_W      = 19,
    parameter int OUT_W     = 16,
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int FRAME_PIX = 262144,
    parameter int CNT_W     = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_en,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_done,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             frame_done,
    output logic             overflow,
    output logic             frame_err
);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_STREAM = 2'd1;
    localparam logic [1:0] c_S_DRAIN  = 2'd2;
    localparam logic [1:0] c_S_DONE   = 2'd3;

    localparam logic [AW:0]      c_FULL  = DEPTH[AW:0];
    localparam logic [CNT_W-1:0] c_FRAME = CNT_W'(FRAME_PIX);
    localparam logic [CNT_W-1:0] c_LAST  = CNT_W'(FRAME_PIX - 1);

    logic [OUT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [CNT_W-1:0] r_pix_cnt;
    logic [1:0]       r_state;
    logic             r_frame_done;
    logic             r_overflow;
    logic             r_frame_err;

    logic [OUT_W-1:0] w_sat;
    logic             w_empty;
    logic             w_full;
    logic             w_rd;
    logic             w_wr;

    // Any set bit above the output width means the result exceeds the
    // output range, so it clamps to all-ones.
    generate
        if (IN_W > OUT_W) begin : g_sat_clamp
            assign w_sat = (|in_data[IN_W-1:OUT_W]) ? {OUT_W{1'b1}}
                                                    : in_data[OUT_W-1:0];
        end else begin : g_sat_pass
            assign w_sat = in_data[OUT_W-1:0];
        end
    endgenerate

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);
    assign w_rd    = !w_empty && out_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_wr    = in_en && (!w_full || w_rd);

    // Storage carries no reset; out_data is gated by out_valid instead.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_sat;
        end
    end

    // Pointers are AW bits wide, so wrap modulo DEPTH happens naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (in_en && w_full && !w_rd) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Frame control. The FIFO is empty throughout DONE, so no read can
    // collide with the pixel-count clear there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_S_IDLE;
            r_pix_cnt    <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;

            if (r_state == c_S_DONE) begin
                r_pix_cnt <= '0;
            end else if (w_rd && (r_pix_cnt != {CNT_W{1'b1}})) begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
            end

            case (r_state)
                c_S_IDLE: begin
                    if (in_done) begin
                        r_state <= c_S_DRAIN;
                    end else if (w_wr) begin
                        r_state <= c_S_STREAM;
                    end
                end
                c_S_STREAM: begin
                    if (in_done) begin
                        r_state <= c_S_DRAIN;
                    end
                end
                c_S_DRAIN: begin
                    // A write landing on an empty FIFO keeps the frame open.
                    if (w_empty && !w_wr) begin
                        r_state      <= c_S_DONE;
                        r_frame_done <= 1'b1;
                    end
                end
                c_S_DONE: begin
                    if (r_pix_cnt != c_FRAME) begin
                        r_frame_err <= 1'b1;
                    end
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign out_valid  = !w_empty;
    assign out_data   = out_valid ? r_mem[r_rd_ptr] : '0;
    assign out_last   = out_valid && (r_pix_cnt == c_LAST);
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;
    assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_conv_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_result_drain
// Purpose  : Self-checking bench for conv_result_drain (DEPTH=4, FRAME_PIX=8)
//            with a queue-based reference model of the output stage.
// Revision : 1.0  initial release
// ============================================================================
module tb_conv_result_drain;

    localparam int IN_W      = 19;
    localparam int OUT_W     = 16;
    localparam int DEPTH     = 4;
    localparam int AW        = 2;
    localparam int FRAME_PIX = 8;
    localparam int PIX_MAX   = 2**19 - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_en = 1'b0;
    logic [IN_W-1:0]  in_data = '0;
    logic             in_done = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_last;
    logic             frame_done;
    logic             overflow;
    logic             frame_err;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of stored pixels, drained-pixel count, flags.
    logic [OUT_W-1:0] q[$];
    int               m_pix;
    bit               m_ovf;
    bit               m_err;
    bit               m_fd;
    bit               m_pend;

    conv_result_drain #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .AW(AW),
        .FRAME_PIX(FRAME_PIX), .CNT_W(19)
    ) dut (
        .clk(clk), .rst(rst), .in_en(in_en), .in_data(in_data),
        .in_done(in_done), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last), .frame_done(frame_done),
        .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] sat(input logic [IN_W-1:0] d);
        if (int'(d) > 2**OUT_W - 1) return {OUT_W{1'b1}};
        return d[OUT_W-1:0];
    endfunction

    task automatic model_clear();
        q.delete();
        m_pix = 0; m_ovf = 0; m_err = 0; m_fd = 0; m_pend = 0;
    endtask

    // Drive one cycle of inputs, advance the model, land 1 time unit past the edge.
    task automatic cycle(input bit en, input logic [IN_W-1:0] d,
                         input bit done, input bit rdy);
        bit rd, full, wr, nfd;
        in_en = en; in_data = d; in_done = done; out_ready = rdy;
        rd   = (q.size() != 0) && rdy;
        full = (q.size() == DEPTH);
        wr   = en && (!full || rd);
        if (en && full && !rd) m_ovf = 1;
        nfd = m_pend && (q.size() == 0) && !wr;
        if (m_fd) begin
            if (m_pix != FRAME_PIX) m_err = 1;
            m_pix = 0;
        end else if (rd && m_pix < PIX_MAX) begin
            m_pix++;
        end
        if (rd) void'(q.pop_front());
        if (wr) q.push_back(sat(d));
        if (nfd) m_pend = 0;
        else if (done && !m_fd) m_pend = 1;
        m_fd = nfd;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; in_en = 0; in_data = '0; in_done = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", out_last); end
        checks++; if ({frame_done, overflow, frame_err} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {frame_done, overflow, frame_err});
        end
    endtask

    task automatic test_frame();
        int lat;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1, IN_W'(i), 0, 1);
            checks++; if (out_valid !== 1'b1 || out_data !== OUT_W'(i)) begin
                errors++; $display("FAIL frame_pix%0d: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, i);
            end
            checks++; if (out_last !== (i == 7)) begin
                errors++; $display("FAIL frame_last%0d: got %b want %b", i, out_last, (i == 7));
            end
            repeat (11) cycle(0, '0, 0, 1);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL frame_gap%0d: got valid %b want 0", i, out_valid); end
        end
        cycle(0, '0, 1, 1);
        lat = 0;
        while (frame_done !== 1'b1 && lat < 8) begin
            checks++; if (frame_done !== m_fd) begin errors++; $display("FAIL frame_done_early: got %b want %b", frame_done, m_fd); end
            cycle(0, '0, 0, 1);
            lat++;
        end
        checks++; if (frame_done !== 1'b1 || lat != 1) begin
            errors++; $display("FAIL frame_done_latency: got fd=%b after %0d extra cycles want fd=1 after 1", frame_done, lat);
        end
        cycle(0, '0, 0, 1);
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_pulse: got %b want 0", frame_done); end
        cycle(0, '0, 0, 1);
        checks++; if (frame_err !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL frame_flags: got err=%b ovf=%b want 0 0", frame_err, overflow);
        end
    endtask

    task automatic test_saturation();
        logic [IN_W-1:0] d;
        do_reset();
        cycle(1, 19'h1FFFF, 0, 0);
        checks++; if (out_data !== 16'hFFFF) begin errors++; $display("FAIL sat_1ffff: got %h want ffff", out_data); end
        cycle(1, 19'h0FFFF, 0, 1);
        checks++; if (out_data !== 16'hFFFF) begin errors++; $display("FAIL sat_0ffff: got %h want ffff", out_data); end
        cycle(1, 19'h00123, 0, 1);
        checks++; if (out_data !== 16'h0123) begin errors++; $display("FAIL sat_00123: got %h want 0123", out_data); end
        cycle(0, '0, 0, 1);
        for (int i = 0; i < 24; i++) begin
            d = IN_W'($urandom);
            cycle(1, d, 0, 1);
            checks++; if (out_valid !== 1'b1 || out_data !== q[0]) begin
                errors++; $display("FAIL sat_rand: in=%h got %h want %h", d, out_data, q[0]);
            end
            cycle(0, '0, 0, 1);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int v = 1; v <= 6; v++) cycle(1, IN_W'(v), 0, 0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        for (int k = 1; k <= 4; k++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== OUT_W'(k)) begin
                errors++; $display("FAIL ovf_drain%0d: got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, k);
            end
            cycle(0, '0, 0, 1);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_full_rw();
        do_reset();
        for (int v = 10; v <= 13; v++) cycle(1, IN_W'(v), 0, 0);
        checks++; if (out_data !== 16'd10) begin errors++; $display("FAIL full_head: got %h want a", out_data); end
        cycle(1, 19'd14, 0, 1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_rw_ovf: got %b want 0", overflow); end
        for (int k = 11; k <= 14; k++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== OUT_W'(k)) begin
                errors++; $display("FAIL full_rw_drain: got v=%b d=%h want v=1 d=%h", out_valid, out_data, k);
            end
            cycle(0, '0, 0, 1);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_rw_count: got %b want 0", out_valid); end
    endtask

    task automatic test_short_frame();
        bit saw_last, saw_fd;
        bit rdy;
        int n;
        do_reset();
        saw_last = 0; saw_fd = 0;
        for (int i = 0; i < 5; i++) begin
            rdy = (q.size() == DEPTH) ? 1'b1 : bit'($urandom_range(0, 1));
            cycle(1, IN_W'($urandom), 0, rdy);
            if (out_last === 1'b1) saw_last = 1;
        end
        cycle(0, '0, 1, 1);
        n = 0;
        while (!saw_fd && n < 20) begin
            if (out_last === 1'b1) saw_last = 1;
            checks++; if (frame_done !== m_fd) begin errors++; $display("FAIL short_fd: got %b want %b", frame_done, m_fd); end
            if (frame_done === 1'b1) saw_fd = 1;
            else cycle(0, '0, 0, 1);
            n++;
        end
        checks++; if (!saw_fd) begin errors++; $display("FAIL short_fd_timeout: got no frame_done want pulse"); end
        cycle(0, '0, 0, 1);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL short_err: got %b want 1", frame_err); end
        checks++; if (saw_last) begin errors++; $display("FAIL short_last: got asserted want never"); end
    endtask

    task automatic test_async_reset();
        int lasts;
        do_reset();
        for (int v = 1; v <= 3; v++) cycle(1, IN_W'(v), 0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL async_pre: got %b want 1", out_valid); end
        #3 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== '0) begin
            errors++; $display("FAIL async_now: got v=%b d=%h want v=0 d=0", out_valid, out_data);
        end
        model_clear();
        in_en = 0; out_ready = 0;
        @(posedge clk); #1 rst = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_release: got %b want 0", out_valid); end
        lasts = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1, IN_W'($urandom), 0, 1);
            if (out_last === 1'b1) lasts++;
            checks++; if (out_data !== q[0] || out_last !== (i == 7)) begin
                errors++; $display("FAIL async_frame%0d: got d=%h l=%b want d=%h l=%b", i, out_data, out_last, q[0], (i == 7));
            end
        end
        checks++; if (lasts != 1) begin errors++; $display("FAIL async_lastcnt: got %0d want 1", lasts); end
    endtask

    task automatic test_random();
        bit en, rdy, done;
        bit exp_last;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            en   = ($urandom_range(0, 99) < 50);
            rdy  = (c < 200) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 80);
            done = ($urandom_range(0, 39) == 0);
            cycle(en, IN_W'($urandom), done, rdy);
            exp_last = (q.size() != 0) && (m_pix == FRAME_PIX - 1);
            checks++; if (out_valid !== (q.size() != 0)) begin
                errors++; $display("FAIL rand_valid c%0d: got %b want %b", c, out_valid, (q.size() != 0));
            end else if (out_valid && out_data !== q[0]) begin
                errors++; $display("FAIL rand_data c%0d: got %h want %h", c, out_data, q[0]);
            end
            checks++; if ({out_last, frame_done, overflow, frame_err} !== {exp_last, m_fd, m_ovf, m_err}) begin
                errors++; $display("FAIL rand_flags c%0d: got l/fd/ovf/err=%b want %b", c,
                    {out_last, frame_done, overflow, frame_err}, {exp_last, m_fd, m_ovf, m_err});
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_saturation();
        test_overflow();
        test_full_rw();
        test_short_frame();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
